// File: rtl/alu_stage_pkg.sv
// Shared ALU definitions: opcode enum and datapath defaults.
// Used by alu_stage and its combinational ALU.
package alu_stage_pkg;

  localparam int WORD_DEF = 8;
  localparam int TAGW_DEF = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_NOT = 3'b101,
    ALU_RSV = 3'b110,
    ALU_NOP = 3'b111
  } alu_op_e;

  function automatic logic is_nop(
    input logic [2:0] op
  );
    return op == ALU_NOP;
  endfunction

endpackage

// File: rtl/alu_stage_alu.sv
// Combinational ALU; SLT and the reserved code yield zero.
// Add/sub wrap modulo 2^WORD with no carry out.
module alu_stage_alu
  import alu_stage_pkg::*;
#(
  parameter int WORD = WORD_DEF
) (
  input  logic [2:0]      op,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic [WORD-1:0] y
);

  // Opcode decode to result
  always_comb begin
    y = '0;
    unique case (alu_op_e'(op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = '0;
      ALU_NOT: y = ~b;
      ALU_RSV: y = '0;
      ALU_NOP: y = a;
    endcase
  end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: ALU plus two-entry output/skid buffer.
// ALU_STAGE_FWD_EN enables forwarding of the last result to A.
module alu_stage
  import alu_stage_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [WORD-1:0] in_a,
  input  logic [WORD-1:0] in_b,
  input  logic [TAGW-1:0] in_rd,
  input  logic            in_fwd_a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_result,
  output logic            out_zero,
  output logic [TAGW-1:0] out_rd,
  output logic            flag_z
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            rdy_q, rdy_d;
  logic [WORD-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic [TAGW-1:0] rd_q, rd_d;
  logic            nop_q, nop_d;
  logic [WORD-1:0] sk_res_q, sk_res_d;
  logic            sk_zero_q, sk_zero_d;
  logic [TAGW-1:0] sk_rd_q, sk_rd_d;
  logic            sk_nop_q, sk_nop_d;
  logic            flag_q, flag_d;

  logic [WORD-1:0] a_op;
  logic [WORD-1:0] alu_y;
  logic            new_zero;
  logic            new_nop;
  logic            acc;
  logic            drain;

`ifdef ALU_STAGE_FWD_EN
  logic [WORD-1:0] last_q, last_d;

  // Operand A mux: forwarded last result or register operand
  always_comb begin
    a_op = in_fwd_a ? last_q : in_a;
  end

  // Last-result register tracks every accepted result
  always_comb begin
    last_d = last_q;
    if (acc) last_d = alu_y;
  end

  // Last-result flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  logic unused_fwd;
  assign unused_fwd = in_fwd_a;

  // Operand A always from the register operand
  always_comb begin
    a_op = in_a;
  end
`endif

  alu_stage_alu #(
    .WORD (WORD)
  ) alu (
    .op (in_op),
    .a  (a_op),
    .b  (in_b),
    .y  (alu_y)
  );

  assign new_zero   = (alu_y == '0);
  assign new_nop    = is_nop(in_op);
  assign acc        = in_valid & rdy_q;
  assign drain      = (state_q != S_EMPTY) & out_ready;
  assign in_ready   = rdy_q;
  assign out_valid  = (state_q != S_EMPTY);
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_rd     = rd_q;
  assign flag_z     = flag_q;

  // Buffer FSM: output slot, skid slot and zero flag update
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    zero_d    = zero_q;
    rd_d      = rd_q;
    nop_d     = nop_q;
    sk_res_d  = sk_res_q;
    sk_zero_d = sk_zero_q;
    sk_rd_d   = sk_rd_q;
    sk_nop_d  = sk_nop_q;
    flag_d    = flag_q;
    unique case (state_q)
      S_EMPTY: begin
        if (acc) begin
          res_d   = alu_y;
          zero_d  = new_zero;
          rd_d    = in_rd;
          nop_d   = new_nop;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (acc && drain) begin
          res_d  = alu_y;
          zero_d = new_zero;
          rd_d   = in_rd;
          nop_d  = new_nop;
        end else if (acc) begin
          sk_res_d  = alu_y;
          sk_zero_d = new_zero;
          sk_rd_d   = in_rd;
          sk_nop_d  = new_nop;
          state_d   = S_FULL;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          res_d   = sk_res_q;
          zero_d  = sk_zero_q;
          rd_d    = sk_rd_q;
          nop_d   = sk_nop_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (drain && !nop_q) flag_d = zero_q;
    rdy_d = (state_d != S_FULL);
  end

  // State and data flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      rdy_q     <= 1'b1;
      res_q     <= '0;
      zero_q    <= 1'b1;
      rd_q      <= '0;
      nop_q     <= 1'b0;
      sk_res_q  <= '0;
      sk_zero_q <= 1'b1;
      sk_rd_q   <= '0;
      sk_nop_q  <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      rd_q      <= rd_d;
      nop_q     <= nop_d;
      sk_res_q  <= sk_res_d;
      sk_zero_q <= sk_zero_d;
      sk_rd_q   <= sk_rd_d;
      sk_nop_q  <= sk_nop_d;
      flag_q    <= flag_d;
    end
  end

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: queue model plus
// directed literal cases and a randomized phase.
module tb_alu_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'd0;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic [1:0] in_rd = 2'd0;
  logic       in_fwd_a = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_zero;
  logic [1:0] out_rd;
  logic       flag_z;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] res;
    logic [1:0] rd;
    logic       nop;
  } ent_t;

  ent_t       q[$];
  logic       flag_m = 1'b0;
  logic [7:0] last_m = 8'd0;

  always #5 clk = ~clk;

  alu_stage #(
    .WORD (8),
    .TAGW (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_fwd_a   (in_fwd_a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .flag_z     (flag_z)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return ~b;
      3'd7:    return a;
      default: return 8'd0;
    endcase
  endfunction

  // Reference model: a FIFO of at most two pending results
  initial forever begin
    logic       acc;
    logic       drn;
    logic [7:0] aa;
    ent_t       e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      flag_m = 1'b0;
      last_m = 8'd0;
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) begin
        e = q.pop_front();
        if (!e.nop) flag_m = (e.res == 8'd0);
      end
      if (acc) begin
        aa = in_a;
`ifdef ALU_STAGE_FWD_EN
        if (in_fwd_a) aa = last_m;
`endif
        e.res = ref_alu(in_op, aa, in_b);
        e.rd  = in_rd;
        e.nop = (in_op == 3'd7);
        last_m = e.res;
        q.push_back(e);
      end
    end
  end

  // Compare DUT against model every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() != 0) begin
        chk("m_out_result", {24'd0, out_result}, {24'd0, q[0].res});
        chk("m_out_zero", {31'd0, out_zero}, {31'd0, q[0].res == 8'd0});
        chk("m_out_rd", {30'd0, out_rd}, {30'd0, q[0].rd});
      end
      chk("m_flag_z", {31'd0, flag_z}, {31'd0, flag_m});
    end
  end

  task automatic issue(input logic [2:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [1:0] rd,
                       input logic       fwd);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    in_fwd_a = fwd;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stuck low @%0t", $time);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_fwd_a = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", {24'd0, out_result}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_out_rd", {30'd0, out_rd}, 32'd0);
    chk("rst_flag_z", {31'd0, flag_z}, 32'd0);

    issue(3'd0, 8'h05, 8'h03, 2'd1, 1'b0);
    idle();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", {24'd0, out_result}, 32'h08);
    chk("add_zero", {31'd0, out_zero}, 32'd0);
    chk("add_flag", {31'd0, flag_z}, 32'd0);

    issue(3'd1, 8'h00, 8'h01, 2'd2, 1'b0);
    idle();
    chk("sub_wrap", {24'd0, out_result}, 32'hFF);

    issue(3'd1, 8'h2A, 8'h2A, 2'd3, 1'b0);
    idle();
    chk("sub_eq_result", {24'd0, out_result}, 32'h00);
    chk("sub_eq_zero", {31'd0, out_zero}, 32'd1);
    @(negedge clk);
    chk("sub_eq_flag", {31'd0, flag_z}, 32'd1);

    issue(3'd1, 8'h05, 8'h01, 2'd0, 1'b0);
    idle();
    chk("sub_nz_result", {24'd0, out_result}, 32'h04);
    issue(3'd7, 8'h00, 8'h09, 2'd1, 1'b0);
    idle();
    chk("nop_zero", {31'd0, out_zero}, 32'd1);
    chk("nop_flag_pre", {31'd0, flag_z}, 32'd0);
    @(negedge clk);
    chk("nop_flag_post", {31'd0, flag_z}, 32'd0);

    out_ready = 1'b0;
    issue(3'd0, 8'h01, 8'h02, 2'd0, 1'b0);
    issue(3'd2, 8'hF0, 8'h3C, 2'd1, 1'b0);
    @(negedge clk);
    in_op = 3'd3;
    in_a  = 8'h0F;
    in_b  = 8'h30;
    in_rd = 2'd2;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_hold", {24'd0, out_result}, 32'h03);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("skid_move", {24'd0, out_result}, 32'h30);
    idle();
    chk("third_result", {24'd0, out_result}, 32'h3F);

    issue(3'd0, 8'h10, 8'h01, 2'd0, 1'b0);
    issue(3'd3, 8'h00, 8'h80, 2'd1, 1'b1);
    idle();
`ifdef ALU_STAGE_FWD_EN
    chk("fwd_or", {24'd0, out_result}, 32'h91);
`else
    chk("fwd_or", {24'd0, out_result}, 32'h80);
`endif

    issue(3'd1, 8'h2A, 8'h2A, 2'd0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_rst_flag", {31'd0, flag_z}, 32'd1);
    out_ready = 1'b0;
    issue(3'd0, 8'h01, 8'h01, 2'd3, 1'b0);
    issue(3'd0, 8'h02, 8'h02, 2'd3, 1'b0);
    idle();
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_flag", {31'd0, flag_z}, 32'd0);
    chk("rst_mid_result", {24'd0, out_result}, 32'd0);
    chk("rst_mid_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_mid_rd", {30'd0, out_rd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_rel_ready", {31'd0, in_ready}, 32'd1);

    repeat (600) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = 8'($urandom_range(0, 255));
      in_b      = 8'($urandom_range(0, 255));
      in_rd     = 2'($urandom_range(0, 3));
      in_fwd_a  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) in_b = in_a;
    end
    idle();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter WORD, default 8, datapath width in bits.
REQ-002 SHALL have parameter TAGW, default 2, destination-register tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream (decode) operation valid.
REQ-006 SHALL have port in_ready, output, 1, stage can accept an operation.
REQ-007 SHALL have port in_op, input, 3, ALU opcode (shared ALU op enum).
REQ-008 SHALL have ports in_a and in_b, input, WORD each, source operands A and B.
REQ-009 SHALL have port in_rd, input, TAGW, destination tag passed through unchanged.
REQ-010 SHALL have port in_fwd_a, input, 1, replace A with last computed result (see Configuration).
REQ-011 SHALL have port out_valid, output, 1, result available to writeback.
REQ-012 SHALL have port out_ready, input, 1, writeback accepts result.
REQ-013 SHALL have ports out_result, output, WORD, and out_zero, output, 1, registered ALU result and zero indication.
REQ-014 SHALL have port out_rd, output, TAGW, tag of the presented result.
REQ-015 SHALL have port flag_z, output, 1, architectural zero flag.

Function
REQ-016 SHALL accept an operation on a clock edge where in_valid and in_ready are both high.
REQ-017 SHALL compute result combinationally from in_op/operands via the ALU sub-module and register it at acceptance; latency exactly 1 cycle (out_valid high the cycle after acceptance when output empty).
REQ-018 SHALL implement ops: ADD 000 A+B, SUB 001 A-B, AND 010, OR 011, NOT 101 ~B, NOP 111 pass A; SLT 100 and 110 yield 0; add/sub wrap modulo 2^WORD, no carry out.
REQ-019 SHALL set out_zero high iff stored result equals 0.
REQ-020 SHALL hold out_result/out_zero/out_rd stable while out_valid high and out_ready low.
REQ-021 SHALL contain a two-entry buffer: output register plus one skid register; states EMPTY (0 held), ONE (output valid), FULL (output and skid valid).
REQ-022 Transitions: EMPTY+accept->ONE; ONE+accept, no drain->FULL; ONE+drain, no accept->EMPTY; ONE+accept+drain->ONE (new result to output); FULL+drain->ONE (skid moves to output); FULL never accepts.
REQ-023 SHALL drive in_ready from a register: high iff state is not FULL (no combinational path out_ready->in_ready).
REQ-024 SHALL preserve strict in-order delivery; no result dropped or duplicated.
REQ-025 SHALL update flag_z to out_zero on each output handshake (out_valid & out_ready), except results from op NOP, which leave flag_z unchanged.
REQ-026 SHALL hold a last-result register loaded with every accepted operation's result.

Reset
REQ-027 On rst_n low, immediately: state EMPTY, out_valid 0, in_ready 1 after release, out_result 0, out_zero 1, out_rd 0, flag_z 0, last-result 0.
REQ-028 Reset mid-operation SHALL discard buffered results; no handshake completes in the reset cycle.

Configuration
REQ-029 Macro ALU_STAGE_FWD_EN defined: when in_fwd_a high at acceptance, operand A SHALL be the last-result register instead of in_a.
REQ-030 Macro undefined: in_fwd_a port present but ignored; A always in_a; last-result register omitted.

Structure
REQ-031 ALU op enum, WORD default and TAGW default SHALL live in the shared project package.
REQ-032 SHALL instantiate the existing combinational ALU as its only sub-module (alu); buffer/FSM in this module.

Verification
REQ-033 Reset then ADD a=8'h05 b=8'h03, out_ready=1 -> next cycle out_valid=1, out_result=8'h08, out_zero=0; flag_z=0.
REQ-034 SUB a=8'h00 b=8'h01 -> out_result=8'hFF; SUB a=8'h2A b=8'h2A -> 8'h00, out_zero=1, flag_z=1 after handshake.
REQ-035 out_ready=0, issue 3 back-to-back ops -> two accepted, in_ready=0 after second; raise out_ready -> results delivered in order, third accepted after first drain.
REQ-036 NOP a=8'h00 after SUB result nonzero -> out_zero=1 but flag_z unchanged.
REQ-037 With ALU_STAGE_FWD_EN: ADD 8'h10+8'h01 then OR in_fwd_a=1 b=8'h80 -> 8'h91; without macro same stimulus, in_a=8'h00 -> 8'h80.
REQ-038 Assert rst_n low while FULL -> out_valid=0 immediately, flag_z=0, in_ready=1 after release.
